// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite RAM arbiter: RAM geometry, controller
// phases and the bit layout of a sprite word.
package sprite_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        LOADING = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Sprite word layout: {x[5:0], y[5:0], color[2:0], stop}
    localparam int SPR_X_MSB     = 15;
    localparam int SPR_X_LSB     = 10;
    localparam int SPR_Y_MSB     = 9;
    localparam int SPR_Y_LSB     = 4;
    localparam int SPR_COLOR_MSB = 3;
    localparam int SPR_COLOR_LSB = 1;
    localparam int SPR_STOP_BIT  = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. On a tie the side that was not granted
// most recently wins; a lone request is granted immediately.
module rr_arb2 (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    logic last_rd;

    always_comb begin
        gnt_wr = 1'b0;
        gnt_rd = 1'b0;
        if (en) begin
            if (req_wr && req_rd) begin
                gnt_wr = last_rd;
                gnt_rd = ~last_rd;
            end else begin
                gnt_wr = req_wr;
                gnt_rd = req_rd;
            end
        end
    end

    // Pointer starts on "read" so the writer wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_rd <= 1'b1;
        end else if (gnt_wr) begin
            last_rd <= 1'b0;
        end else if (gnt_rd) begin
            last_rd <= 1'b1;
        end
    end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Shares the single-port sprite RAM between the loader (writes) and the
// drawing engine (reads), sequencing load / run / reload phases.
module sprite_ram_arbiter #(
    parameter int ADDR_W     = sprite_pkg::ADDR_W,
    parameter int DATA_W     = sprite_pkg::DATA_W,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              load_done,
    input  logic              reload,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    import sprite_pkg::*;

    state_t              state;
    state_t              state_next;
    logic                arb_en;
    logic                arb_gnt_wr;
    logic                arb_gnt_rd;
    logic [RD_LATENCY:0] vpipe;
    logic                vtail;

    assign arb_en = (state == RUN) && !reload;
    assign vtail  = vpipe[RD_LATENCY];

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .en     (arb_en),
        .req_wr (wr_req),
        .req_rd (rd_req),
        .gnt_wr (arb_gnt_wr),
        .gnt_rd (arb_gnt_rd)
    );

    // While loading, the writer bypasses the arbiter so the tie pointer only
    // tracks RUN-phase traffic.
    always_comb begin
        state_next = state;
        wr_ack     = 1'b0;
        rd_ack     = 1'b0;
        case (state)
            LOADING: begin
                wr_ack = wr_req;
                if (load_done && !wr_req) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                wr_ack = arb_gnt_wr;
                rd_ack = arb_gnt_rd;
                if (reload) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (vpipe == '0) begin
                    state_next = LOADING;
                end
            end
            default: state_next = LOADING;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= LOADING;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == RUN);
        end
    end

    // Address, data and write enable are registered together so the RAM
    // always sees a coherent access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
        end else begin
            ram_wren <= wr_ack;
            if (wr_ack) begin
                ram_addr <= wr_addr;
                ram_data <= wr_data;
            end else if (rd_ack) begin
                ram_addr <= rd_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vpipe    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            vpipe    <= {vpipe[RD_LATENCY-1:0], rd_ack};
            rd_valid <= vtail;
            if (vtail) begin
                rd_data <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_sprite_ram_arbiter.sv
// Self-checking bench: two arbiters (read latency 1 and 2) share stimulus;
// read results are predicted from a reference memory and scoreboarded.
module tb_sprite_ram_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;
    localparam int RD_LAT1 = 1;
    localparam int RD_LAT2 = 2;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              load_done;
    logic              reload;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;

    logic              wr_ack,   wr_ack2;
    logic              rd_ack,   rd_ack2;
    logic              rd_valid, rd_valid2;
    logic [DATA_W-1:0] rd_data,  rd_data2;
    logic              ready,    ready2;
    logic [ADDR_W-1:0] ram_addr, ram_addr2;
    logic [DATA_W-1:0] ram_data, ram_data2;
    logic              ram_wren, ram_wren2;
    logic [DATA_W-1:0] ram_q,    ram_q2;

    logic [DATA_W-1:0] mem1    [1024];
    logic [DATA_W-1:0] mem2    [1024];
    logic [DATA_W-1:0] exp_mem [1024];
    logic [DATA_W-1:0] q2a;

    exp_t sb1 [$];
    exp_t sb2 [$];
    exp_t e1, e2;

    int cyc         = 0;
    int check_count = 0;
    int error_count = 0;
    int wn, rn;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT1)) u_dut (
        .clk(clk), .resetn(resetn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .load_done(load_done), .reload(reload),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .ready(ready),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    sprite_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT2)) u_dut2 (
        .clk(clk), .resetn(resetn),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack2),
        .load_done(load_done), .reload(reload),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack2),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .ready(ready2),
        .ram_addr(ram_addr2), .ram_data(ram_data2), .ram_wren(ram_wren2), .ram_q(ram_q2)
    );

    // Behavioural single-port RAMs with one and two cycles of read latency.
    always @(posedge clk) begin
        if (ram_wren) mem1[ram_addr] <= ram_data;
        ram_q <= mem1[ram_addr];
        if (ram_wren2) mem2[ram_addr2] <= ram_data2;
        q2a    <= mem2[ram_addr2];
        ram_q2 <= q2a;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input int wr, input int wa, input int wd,
                                 input int rd, input int ra, input int ld, input int rl);
        @(posedge clk);
        #1;
        wr_req    = 1'(wr);
        wr_addr   = ADDR_W'(wa);
        wr_data   = DATA_W'(wd);
        rd_req    = 1'(rd);
        rd_addr   = ADDR_W'(ra);
        load_done = 1'(ld);
        reload    = 1'(rl);
    endtask

    // Scoreboard: predict at grant time, compare when rd_valid appears.
    always @(negedge clk) begin
        if (resetn) begin
            if (wr_ack) exp_mem[wr_addr] = wr_data;
            if (rd_ack)  sb1.push_back(exp_t'{data: exp_mem[rd_addr], due: cyc + RD_LAT1 + 2});
            if (rd_ack2) sb2.push_back(exp_t'{data: exp_mem[rd_addr], due: cyc + RD_LAT2 + 2});

            if (rd_valid) begin
                if (sb1.size() == 0) begin
                    checkOutput("lat1_spurious_valid", 32'(rd_valid), 0);
                end else begin
                    e1 = sb1.pop_front();
                    checkOutput("lat1_rd_data", 32'(rd_data), 32'(e1.data));
                    checkOutput("lat1_rd_cycle", 32'(cyc), 32'(e1.due));
                end
            end else if (sb1.size() != 0 && sb1[0].due <= cyc) begin
                checkOutput("lat1_missing_valid", 32'(rd_valid), 1);
                void'(sb1.pop_front());
            end

            if (rd_valid2) begin
                if (sb2.size() == 0) begin
                    checkOutput("lat2_spurious_valid", 32'(rd_valid2), 0);
                end else begin
                    e2 = sb2.pop_front();
                    checkOutput("lat2_rd_data", 32'(rd_data2), 32'(e2.data));
                    checkOutput("lat2_rd_cycle", 32'(cyc), 32'(e2.due));
                end
            end else if (sb2.size() != 0 && sb2[0].due <= cyc) begin
                checkOutput("lat2_missing_valid", 32'(rd_valid2), 1);
                void'(sb2.pop_front());
            end
        end
    end

    initial begin
        resetn = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        load_done = 1'b0; reload = 1'b0; rd_req = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ram_wren", 32'(ram_wren), 0);
        checkOutput("rst_ram_addr", 32'(ram_addr), 0);
        checkOutput("rst_ram_data", 32'(ram_data), 0);
        checkOutput("rst_rd_data",  32'(rd_data), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_ready",    32'(ready), 0);
        resetn = 1'b1;

        // Loading: only writes are granted
        applyStimulus(1, 5, 'h5A3F, 1, 5, 0, 0);
        @(negedge clk);
        checkOutput("load_wr_ack", 32'(wr_ack), 1);
        checkOutput("load_rd_ack", 32'(rd_ack), 0);
        applyStimulus(0, 0, 0, 1, 5, 0, 0);
        checkOutput("wr_ram_wren", 32'(ram_wren), 1);
        checkOutput("wr_ram_addr", 32'(ram_addr), 5);
        checkOutput("wr_ram_data", 32'(ram_data), 'h5A3F);
        @(negedge clk);
        checkOutput("load_rd_blocked", 32'(rd_ack), 0);
        checkOutput("load_ready", 32'(ready), 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, i, 'h1000 + i * 'h111, 0, 0, 0, 0);

        // load_done coinciding with a write grant defers the RUN transition
        applyStimulus(1, 9, 'hBEEF, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("ld_wr_ack", 32'(wr_ack), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("ld_deferred_ready", 32'(ready), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("run_ready", 32'(ready), 1);
        checkOutput("run_ready2", 32'(ready2), 1);

        // Single read of address 5
        applyStimulus(0, 0, 0, 1, 5, 0, 0);
        @(negedge clk);
        checkOutput("run_rd_ack", 32'(rd_ack), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rd_ram_wren", 32'(ram_wren), 0);
        checkOutput("rd_ram_addr", 32'(ram_addr), 5);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Read in the cycle right after a write to the same address
        applyStimulus(1, 9, 'hC0DE, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("raw_wr_ack", 32'(wr_ack), 1);
        applyStimulus(0, 0, 0, 1, 9, 0, 0);
        @(negedge clk);
        checkOutput("raw_rd_ack", 32'(rd_ack), 1);
        repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Contention alternates W,R,W,R,W,R starting with the writer
        wn = 0; rn = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 'h100 + wn, 'h2000 + wn, 1, rn, 0, 0);
            @(negedge clk);
            checkOutput("alt_wr_ack", 32'(wr_ack), 32'(i % 2 == 0));
            checkOutput("alt_rd_ack", 32'(rd_ack), 32'(i % 2 == 1));
            if (wr_ack) wn++;
            if (rd_ack) rn++;
        end
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Back-to-back reads of 0,1,2
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, i, 0, 0);
            @(negedge clk);
            checkOutput("b2b_rd_ack", 32'(rd_ack), 1);
        end
        repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Reload with two reads in flight
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("rl_rd_ack_a", 32'(rd_ack), 1);
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("rl_rd_ack_b", 32'(rd_ack), 1);
        applyStimulus(1, 'h3FF, 'hFFFF, 1, 2, 0, 1);
        @(negedge clk);
        checkOutput("rl_rd_override", 32'(rd_ack), 0);
        checkOutput("rl_wr_override", 32'(wr_ack), 0);
        checkOutput("rl_wr_override2", 32'(wr_ack2), 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 'h3FF, 'hFFFF, 1, 2, 0, 0);
            if (k == 0) checkOutput("drain_ready", 32'(ready), 0);
            @(negedge clk);
            checkOutput("drain_rd_ack",  32'(rd_ack), 0);
            checkOutput("drain_rd_ack2", 32'(rd_ack2), 0);
            checkOutput("drain_wr_ack",  32'(wr_ack), 32'(k >= 2));
            checkOutput("drain_wr_ack2", 32'(wr_ack2), 32'(k >= 3));
        end

        // reload is ignored in LOADING
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("reload_ignored_ready", 32'(ready), 1);

        // Reset one cycle after a read grant aborts it
        applyStimulus(0, 0, 0, 1, 'h3FF, 0, 0);
        @(negedge clk);
        checkOutput("abort_rd_ack", 32'(rd_ack), 1);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        rd_req = 1'b0;
        sb1.delete();
        sb2.delete();
        #1;
        checkOutput("mid_rst_ram_addr", 32'(ram_addr), 0);
        checkOutput("mid_rst_ready",    32'(ready), 0);
        checkOutput("mid_rst_rd_valid", 32'(rd_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        checkOutput("post_rst_rd_ack", 32'(rd_ack), 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("post_rst_rd_valid",  32'(rd_valid), 0);
            checkOutput("post_rst_rd_valid2", 32'(rd_valid2), 0);
        end
        checkOutput("post_rst_rd_data",  32'(rd_data), 0);
        checkOutput("post_rst_ram_wren", 32'(ram_wren), 0);
        checkOutput("post_rst_ram_data", 32'(ram_data), 0);
        checkOutput("post_rst_ready",    32'(ready), 0);

        checkOutput("sb1_drained", 32'(sb1.size()), 0);
        checkOutput("sb2_drained", 32'(sb2.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
